// File: rtl/parity_frame_checker_v.sv
// Framed nibble parity checker: collects FRAME_LEN data nibbles, compares the
// running parity against a trailing check nibble and holds the result until taken.
module parity_frame_checker_v #(
  parameter int FRAME_LEN  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [3:0]           i_nibble,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_err,
  output logic                 o_fmt_err,
  output logic                 o_par,
  output logic [FRAME_LEN-1:0] o_syndrome,
  output logic [7:0]           o_err_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {COLLECT, CHECK, REPORT} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 runPar_q;
  logic [FRAME_LEN-1:0] syn_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 fmtErr_q;
  logic                 par_q;
  logic [FRAME_LEN-1:0] outSyn_q;
  logic [7:0]           errCnt_q;

  logic nibPar;
  logic framePar_d;
  logic mismatch_d;

  assign nibPar     = ^i_nibble;
  assign framePar_d = runPar_q ^ PARITY_ODD;
  assign mismatch_d = framePar_d != i_nibble[0];

  // Ready depends only on state and reset so it never loops back through i_valid.
  assign o_ready = i_rst_n && (state_q != REPORT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      runPar_q <= 1'b0;
      syn_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      fmtErr_q <= 1'b0;
      par_q    <= 1'b0;
      outSyn_q <= '0;
      errCnt_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (i_valid) begin
            syn_q[cnt_q] <= nibPar;
            runPar_q     <= runPar_q ^ nibPar;
            cnt_q        <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (i_valid) begin
            par_q    <= framePar_d;
            err_q    <= mismatch_d;
            fmtErr_q <= |i_nibble[3:1];
            outSyn_q <= syn_q;
            if (mismatch_d && (errCnt_q != 8'hFF)) errCnt_q <= errCnt_q + 8'd1;
            valid_q  <= 1'b1;
            state_q  <= REPORT;
          end
        end
        REPORT: begin
          // Result fields stay put here; only the frame accumulators are cleared.
          if (i_ready) begin
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            runPar_q <= 1'b0;
            syn_q    <= '0;
            state_q  <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_fmt_err  = fmtErr_q;
  assign o_par      = par_q;
  assign o_syndrome = outSyn_q;
  assign o_err_cnt  = errCnt_q;

endmodule

// File: tb/tb_parity_frame_checker_v.sv
// Scoreboard bench for parity_frame_checker_v: an even-parity 4-beat instance
// and an odd-parity 2-beat instance, each checked against a bench-side model.
module tb_parity_frame_checker_v;

  typedef struct packed {
    logic [31:0] syn;
    logic        par;
    logic        err;
    logic        fmt;
    logic [7:0]  cnt;
  } result_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  result_t qA[$];
  result_t qB[$];
  int errCntModelA = 0;
  int errCntModelB = 0;

  logic       rstA, validA, readyInA;
  logic [3:0] nibbleA;
  logic       oReadyA, oValidA, oErrA, oFmtA, oParA;
  logic [3:0] oSynA;
  logic [7:0] oCntA;

  logic       rstB, validB, readyInB;
  logic [3:0] nibbleB;
  logic       oReadyB, oValidB, oErrB, oFmtB, oParB;
  logic [1:0] oSynB;
  logic [7:0] oCntB;

  parity_frame_checker_v #(.FRAME_LEN(4), .PARITY_ODD(1'b0)) dutA (
    .i_clk(clk), .i_rst_n(rstA), .i_valid(validA), .i_nibble(nibbleA),
    .o_ready(oReadyA), .o_valid(oValidA), .i_ready(readyInA), .o_err(oErrA),
    .o_fmt_err(oFmtA), .o_par(oParA), .o_syndrome(oSynA), .o_err_cnt(oCntA)
  );

  parity_frame_checker_v #(.FRAME_LEN(2), .PARITY_ODD(1'b1)) dutB (
    .i_clk(clk), .i_rst_n(rstB), .i_valid(validB), .i_nibble(nibbleB),
    .o_ready(oReadyB), .o_valid(oValidB), .i_ready(readyInB), .o_err(oErrB),
    .o_fmt_err(oFmtB), .o_par(oParB), .o_syndrome(oSynB), .o_err_cnt(oCntB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Pop and compare one expected result each time o_valid rises.
  logic prevValidA = 1'b0;
  logic prevValidB = 1'b0;
  result_t expA, expB;

  always @(negedge clk) begin
    if (oValidA && !prevValidA) begin
      if (qA.size() == 0) checkOutput("queueEmptyA", 32'd1, 32'd0);
      else begin
        expA = qA.pop_front();
        checkOutput("synA", {28'd0, oSynA}, expA.syn);
        checkOutput("parA", {31'd0, oParA}, {31'd0, expA.par});
        checkOutput("errA", {31'd0, oErrA}, {31'd0, expA.err});
        checkOutput("fmtA", {31'd0, oFmtA}, {31'd0, expA.fmt});
        checkOutput("cntA", {24'd0, oCntA}, {24'd0, expA.cnt});
      end
    end
    prevValidA = oValidA;
  end

  always @(negedge clk) begin
    if (oValidB && !prevValidB) begin
      if (qB.size() == 0) checkOutput("queueEmptyB", 32'd1, 32'd0);
      else begin
        expB = qB.pop_front();
        checkOutput("synB", {30'd0, oSynB}, expB.syn);
        checkOutput("parB", {31'd0, oParB}, {31'd0, expB.par});
        checkOutput("errB", {31'd0, oErrB}, {31'd0, expB.err});
        checkOutput("fmtB", {31'd0, oFmtB}, {31'd0, expB.fmt});
        checkOutput("cntB", {24'd0, oCntB}, {24'd0, expB.cnt});
      end
    end
    prevValidB = oValidB;
  end

  // Drives one 4-beat frame plus check nibble into dutA, optionally stalling in REPORT.
  task automatic applyStimulusA(input logic [15:0] data, input logic [3:0] chk,
                                input int holdCycles);
    result_t e;
    logic rp;
    e = '0;
    rp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.syn[i] = ^data[4*i +: 4];
      rp ^= e.syn[i];
    end
    e.par = rp;
    e.err = (e.par != chk[0]);
    e.fmt = |chk[3:1];
    if (e.err && errCntModelA < 255) errCntModelA++;
    e.cnt = 8'(errCntModelA);
    qA.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("beatReadyA", {31'd0, oReadyA}, 32'd1);
      validA  = 1'b1;
      nibbleA = data[4*i +: 4];
    end
    @(negedge clk);
    validA  = 1'b1;
    nibbleA = chk;
    @(negedge clk);
    validA = 1'b0;
    checkOutput("latencyA", {31'd0, oValidA}, 32'd1);
    for (int h = 0; h < holdCycles; h++) begin
      validA   = 1'b1;
      nibbleA  = 4'hA;
      readyInA = 1'b0;
      @(negedge clk);
      checkOutput("holdValidA", {31'd0, oValidA}, 32'd1);
      checkOutput("holdReadyA", {31'd0, oReadyA}, 32'd0);
      checkOutput("holdSynA", {28'd0, oSynA}, e.syn);
      checkOutput("holdErrA", {31'd0, oErrA}, {31'd0, e.err});
      checkOutput("holdParA", {31'd0, oParA}, {31'd0, e.par});
    end
    validA   = 1'b0;
    readyInA = 1'b1;
    @(negedge clk);
    readyInA = 1'b0;
    checkOutput("releaseValidA", {31'd0, oValidA}, 32'd0);
    checkOutput("releaseReadyA", {31'd0, oReadyA}, 32'd1);
  endtask

  task automatic applyStimulusB(input logic [7:0] data, input logic [3:0] chk);
    result_t e;
    logic rp;
    e = '0;
    rp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.syn[i] = ^data[4*i +: 4];
      rp ^= e.syn[i];
    end
    e.par = ~rp;
    e.err = (e.par != chk[0]);
    e.fmt = |chk[3:1];
    if (e.err && errCntModelB < 255) errCntModelB++;
    e.cnt = 8'(errCntModelB);
    qB.push_back(e);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      validB  = 1'b1;
      nibbleB = data[4*i +: 4];
    end
    @(negedge clk);
    validB  = 1'b1;
    nibbleB = chk;
    @(negedge clk);
    validB   = 1'b0;
    checkOutput("latencyB", {31'd0, oValidB}, 32'd1);
    readyInB = 1'b1;
    @(negedge clk);
    readyInB = 1'b0;
    checkOutput("releaseValidB", {31'd0, oValidB}, 32'd0);
  endtask

  initial begin
    rstA = 1'b0; validA = 1'b0; readyInA = 1'b0; nibbleA = 4'h0;
    rstB = 1'b0; validB = 1'b0; readyInB = 1'b0; nibbleB = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("rstReadyA", {31'd0, oReadyA}, 32'd0);
    checkOutput("rstValidA", {31'd0, oValidA}, 32'd0);
    checkOutput("rstOutsA", {20'd0, oErrA, oFmtA, oParA, oSynA, oCntA}, 32'd0);
    checkOutput("rstOutsB", {20'd0, oValidB, oErrB, oParB, oSynB, oCntB, oReadyB}, 32'd0);
    rstA = 1'b1;
    rstB = 1'b1;
    @(negedge clk);
    checkOutput("postRstReadyA", {31'd0, oReadyA}, 32'd1);

    applyStimulusA(16'hF731, 4'h0, 0);
    applyStimulusA(16'hF731, 4'h1, 0);
    applyStimulusA(16'h0000, 4'h2, 0);
    applyStimulusA(16'hF731, 4'h0, 5);
    applyStimulusA(16'h0001, 4'h1, 0);
    for (int n = 0; n < 256; n++) applyStimulusA(16'hF731, 4'h1, 0);
    checkOutput("satCntA", {24'd0, oCntA}, 32'd255);

    // Abort a frame after two accepted beats; nothing may be reported for it.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      validA  = 1'b1;
      nibbleA = 4'h1;
    end
    @(negedge clk);
    validA = 1'b0;
    rstA   = 1'b0;
    @(negedge clk);
    errCntModelA = 0;
    checkOutput("midRstReadyA", {31'd0, oReadyA}, 32'd0);
    checkOutput("midRstOutsA", {20'd0, oValidA, oErrA, oFmtA, oParA, oSynA, oCntA}, 32'd0);
    rstA = 1'b1;
    @(negedge clk);
    checkOutput("midRstRelReadyA", {31'd0, oReadyA}, 32'd1);
    applyStimulusA(16'h0000, 4'h0, 0);

    applyStimulusB(8'h00, 4'h1);
    applyStimulusB(8'h00, 4'h0);
    applyStimulusB(8'h31, 4'h1);

    repeat (2) @(negedge clk);
    checkOutput("drainA", qA.size(), 32'd0);
    checkOutput("drainB", qB.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker_v.md
# parity_frame_checker_v

Sequential parity checker that consumes a stream of 4-bit nibbles over a valid/ready handshake. It computes the 4-input XOR parity of each nibble, packs the per-nibble parities into a syndrome vector, and accumulates a running frame parity. At the end of each frame it compares the frame parity against a trailing check nibble and reports the result, holding it until the consumer accepts it. It sits directly downstream of the nibble source and wraps the xor4 parity reduction into a framed, back-pressurable checker.

## Interface
- FRAME_LEN, 8, data nibbles per frame; legal range 2..32.
- PARITY_ODD, 0, 0 = even parity (check bit = XOR of all data bits); 1 = odd parity (check bit inverted).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  nibble present on i_nibble.
- i_nibble  in  4  data nibble, or check nibble on the final beat.
- o_ready  out  1  block accepts a nibble this cycle.
- o_valid  out  1  frame result available.
- i_ready  in  1  consumer accepts the frame result.
- o_err  out  1  frame parity mismatch.
- o_fmt_err  out  1  check nibble bits [3:1] nonzero.
- o_par  out  1  computed frame parity, after PARITY_ODD inversion.
- o_syndrome  out  FRAME_LEN  per-nibble parity; bit k = parity of data beat k.
- o_err_cnt  out  8  count of frames with o_err=1; saturates at 255.

## Operation
- Nibble parity: p = i_nibble[3]^i_nibble[2]^i_nibble[1]^i_nibble[0].
- Beat counter width: $clog2(FRAME_LEN).
- Accept rule: a nibble is consumed only when i_valid && o_ready at the rising edge.
- COLLECT state:
  - o_ready=1.
  - On accept: syndrome[cnt] <= p; run_par <= run_par ^ p; cnt <= cnt+1.
  - When the accepted beat has cnt == FRAME_LEN-1, go to CHECK.
- CHECK state:
  - o_ready=1.
  - On accept: o_par <= run_par ^ PARITY_ODD.
  - o_err <= (run_par ^ PARITY_ODD) != i_nibble[0].
  - o_fmt_err <= |i_nibble[3:1].
  - o_syndrome <= syndrome.
  - o_err_cnt increments if the mismatch holds and the count is below 255.
  - Go to REPORT.
- REPORT state:
  - o_valid=1, o_ready=0; result outputs held stable.
  - Input nibbles are ignored, even if i_valid=1.
  - When i_ready=1: clear cnt, run_par and syndrome, then go to COLLECT.
  - o_err, o_fmt_err, o_par and o_syndrome keep their last value until the next CHECK accept.
- o_fmt_err does not affect o_err; o_err uses only i_nibble[0].
- i_valid low in any state causes a stall; no state change.

## Timing
- Reset (i_rst_n=0 at an edge):
  - State goes to COLLECT; cnt, run_par, syndrome cleared.
  - o_valid, o_err, o_fmt_err, o_par, o_syndrome and o_err_cnt all 0.
  - o_ready is forced 0 while i_rst_n=0 and becomes 1 the first cycle after release.
- Reset mid-frame or in REPORT discards the partial frame or pending result; no result is emitted for it.
- Throughput: one nibble per cycle in COLLECT/CHECK; a frame takes FRAME_LEN+1 accept cycles.
- Latency: o_valid rises the cycle after the check nibble is accepted.
- Release: if i_ready=1 in the first REPORT cycle, o_valid is a 1-cycle pulse and o_ready returns to 1 the next cycle.
- Minimum frame period is FRAME_LEN+2 cycles. There is no overlap between REPORT and nibble acceptance.
- o_ready is a combinational function of state and i_rst_n only. It never depends on i_valid.

## Test plan
- FRAME_LEN=4, PARITY_ODD=0:
  - Nibbles 0x1,0x3,0x7,0xF then check 0x0 -> o_syndrome=4'b0101, o_par=0, o_err=0, o_fmt_err=0, o_err_cnt=0. o_valid rises 1 cycle after the check beat.
- Same data, check 0x1 -> o_err=1, o_err_cnt=1.
- Repeat that frame 256 times -> o_err_cnt holds at 255.
- Check nibble 0x2 after data with run_par=0 -> o_fmt_err=1, o_err=0.
- Backpressure:
  - Hold i_ready=0 for 5 cycles in REPORT while driving i_valid=1 with 0xA -> o_valid=1, o_ready=0 and outputs stable throughout.
  - 0xA is not consumed; the next frame's syndrome reflects only nibbles sent after i_ready=1.
- Reset mid-frame:
  - Assert i_rst_n=0 for 1 cycle after 2 accepted nibbles -> all outputs 0.
  - The next full frame 0x0 x4 plus check 0x0 gives o_err=0, o_syndrome=4'b0000.
- PARITY_ODD=1, FRAME_LEN=2:
  - Data 0x0,0x0 with check 0x1 -> o_par=1, o_err=0.
  - Check 0x0 -> o_err=1.
